// File: rtl/timing_pkg.sv
// timing_pkg: shared video timing defaults (1920x1080 CEA timing) and per-axis phase encoding.
package timing_pkg;
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axisState_t;
    localparam int DEF_BUS_WIDTH = 12;
    localparam int DEF_H_ACTIVE  = 1920;
    localparam int DEF_H_FP      = 88;
    localparam int DEF_H_SYNC    = 44;
    localparam int DEF_H_BP      = 148;
    localparam int DEF_V_ACTIVE  = 1080;
    localparam int DEF_V_FP      = 4;
    localparam int DEF_V_SYNC    = 5;
    localparam int DEF_V_BP      = 36;
    function automatic int axisTotal(int a, int f, int s, int b);
        return a + f + s + b;
    endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one timing axis -- position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// wrap is combinational so a following axis can step on the same clock.
module timing_axis
    import timing_pkg::*;
#(
    parameter int busWidth  = DEF_BUS_WIDTH,
    parameter int activeLen = DEF_H_ACTIVE,
    parameter int fpLen     = DEF_H_FP,
    parameter int syncLen   = DEF_H_SYNC,
    parameter int bpLen     = DEF_H_BP
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                step,
    output logic [busWidth-1:0] count,
    output logic [1:0]          nextState,
    output logic                wrap
);
    localparam int total = axisTotal(activeLen, fpLen, syncLen, bpLen);
    localparam logic [busWidth-1:0] lastIdx    = busWidth'(total - 1);
    localparam logic [busWidth-1:0] one        = busWidth'(1);
    localparam logic [busWidth-1:0] frontStart = busWidth'(activeLen);
    localparam logic [busWidth-1:0] syncStart  = busWidth'(activeLen + fpLen);
    localparam logic [busWidth-1:0] backStart  = busWidth'(activeLen + fpLen + syncLen);

    if (activeLen < 1 || fpLen < 0 || syncLen < 0 || bpLen < 0 || total > 2 ** busWidth) begin : gBadTiming
        $error("timing_axis: timing total %0d does not fit in %0d bits", total, busWidth);
    end

    axisState_t state, stateNext;
    logic [busWidth-1:0] countNext;

    assign wrap      = step && count == lastIdx;
    assign nextState = stateNext;

    // Later phases are tested first so a zero-length phase yields to the one sharing its start.
    always_comb begin
        countNext = !step ? count : wrap ? '0 : count + one;
        stateNext = state;
        if (step) begin
            if (bpLen > 0 && countNext == backStart) stateNext = BACK;
            else if (syncLen > 0 && countNext == syncStart) stateNext = SYNC;
            else if (fpLen > 0 && countNext == frontStart) stateNext = FRONT;
            else if (countNext == '0) stateNext = ACTIVE;
        end
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            count <= '0;
            state <= ACTIVE;
        end else begin
            count <= countNext;
            state <= stateNext;
        end
endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator; all flags are registered from the axes' next
// phase so they line up with hCount/vCount on the same cycle.
module video_timing_ctrl
    import timing_pkg::*;
#(
    parameter int   busWidth = DEF_BUS_WIDTH,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    output logic [busWidth-1:0] hCount,
    output logic [busWidth-1:0] vCount,
    output logic                hSync,
    output logic                vSync,
    output logic                dataEnable,
    output logic                lineStart,
    output logic                frameStart
);
    logic [1:0] hState, vState;
    logic hWrap, vWrap;

    timing_axis #(
        .busWidth(busWidth), .activeLen(H_ACTIVE), .fpLen(H_FP), .syncLen(H_SYNC), .bpLen(H_BP)
    ) hAxis (
        .clock(clock), .reset_n(reset_n), .step(enable),
        .count(hCount), .nextState(hState), .wrap(hWrap)
    );

    timing_axis #(
        .busWidth(busWidth), .activeLen(V_ACTIVE), .fpLen(V_FP), .syncLen(V_SYNC), .bpLen(V_BP)
    ) vAxis (
        .clock(clock), .reset_n(reset_n), .step(hWrap),
        .count(vCount), .nextState(vState), .wrap(vWrap)
    );

    // Axis phases hold while stepping is off, so the level flags hold without an enable term.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            hSync      <= ~SYNC_POL;
            vSync      <= ~SYNC_POL;
            dataEnable <= 1'b1;
            lineStart  <= 1'b1;
            frameStart <= 1'b1;
        end else begin
            hSync      <= (hState == SYNC) ? SYNC_POL : ~SYNC_POL;
            vSync      <= (vState == SYNC) ? SYNC_POL : ~SYNC_POL;
            dataEnable <= hState == ACTIVE && vState == ACTIVE;
            lineStart  <= hWrap;
            frameStart <= vWrap;
        end
endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: four instances (default, general small, zero porches, inverted polarity)
// checked every cycle against a frame-position reference model.
module tb_video_timing_ctrl;
    logic clock = 1'b0;
    logic reset_n, enable;
    always #5 clock = ~clock;

    logic [11:0] hc0, vc0;
    logic [4:0]  hc1, vc1;
    logic [3:0]  hc2, vc2, hc3, vc3;
    logic hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
    logic hs2, vs2, de2, ls2, fs2, hs3, vs3, de3, ls3, fs3;

    video_timing_ctrl u0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .hCount(hc0), .vCount(vc0),
        .hSync(hs0), .vSync(vs0), .dataEnable(de0), .lineStart(ls0), .frameStart(fs0)
    );
    video_timing_ctrl #(
        .busWidth(5), .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_POL(1'b1)
    ) u1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .hCount(hc1), .vCount(vc1),
        .hSync(hs1), .vSync(vs1), .dataEnable(de1), .lineStart(ls1), .frameStart(fs1)
    );
    video_timing_ctrl #(
        .busWidth(4), .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(0), .SYNC_POL(1'b1)
    ) u2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .hCount(hc2), .vCount(vc2),
        .hSync(hs2), .vSync(vs2), .dataEnable(de2), .lineStart(ls2), .frameStart(fs2)
    );
    video_timing_ctrl #(
        .busWidth(4), .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(0), .SYNC_POL(1'b0)
    ) u3 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .hCount(hc3), .vCount(vc3),
        .hSync(hs3), .vSync(vs3), .dataEnable(de3), .lineStart(ls3), .frameStart(fs3)
    );

    logic [31:0] obsH [4];
    logic [31:0] obsV [4];
    logic [4:0]  obsF [4];
    assign obsH[0] = 32'(hc0);
    assign obsH[1] = 32'(hc1);
    assign obsH[2] = 32'(hc2);
    assign obsH[3] = 32'(hc3);
    assign obsV[0] = 32'(vc0);
    assign obsV[1] = 32'(vc1);
    assign obsV[2] = 32'(vc2);
    assign obsV[3] = 32'(vc3);
    assign obsF[0] = {hs0, vs0, de0, ls0, fs0};
    assign obsF[1] = {hs1, vs1, de1, ls1, fs1};
    assign obsF[2] = {hs2, vs2, de2, ls2, fs2};
    assign obsF[3] = {hs3, vs3, de3, ls3, fs3};

    // Reference timing per instance; the model tracks a linear pixel index within the frame.
    int hA [4] = '{1920, 16, 8, 8};
    int hF [4] = '{88, 3, 0, 0};
    int hS [4] = '{44, 4, 2, 2};
    int hB [4] = '{148, 5, 2, 2};
    int vA [4] = '{1080, 6, 4, 4};
    int vF [4] = '{4, 2, 1, 1};
    int vS [4] = '{5, 3, 1, 1};
    int vB [4] = '{36, 4, 0, 0};
    bit pol [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    int pos [4];
    bit expLs [4];
    bit expFs [4];
    int compared = 0;
    int mismatched = 0;

    function automatic int hTot(int i);
        return hA[i] + hF[i] + hS[i] + hB[i];
    endfunction

    function automatic int fTot(int i);
        return hTot(i) * (vA[i] + vF[i] + vS[i] + vB[i]);
    endfunction

    function automatic logic [4:0] expFlags(int i);
        int h = pos[i] % hTot(i);
        int v = pos[i] / hTot(i);
        bit inH = h >= hA[i] + hF[i] && h < hA[i] + hF[i] + hS[i];
        bit inV = v >= vA[i] + vF[i] && v < vA[i] + vF[i] + vS[i];
        return {inH ? pol[i] : !pol[i], inV ? pol[i] : !pol[i], h < hA[i] && v < vA[i], expLs[i], expFs[i]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0;
            expLs[i] = 1'b1;
            expFs[i] = 1'b1;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 4; i++) begin
            if (enable) begin
                pos[i] = (pos[i] + 1) % fTot(i);
                expLs[i] = pos[i] % hTot(i) == 0;
                expFs[i] = pos[i] == 0;
            end else begin
                expLs[i] = 1'b0;
                expFs[i] = 1'b0;
            end
        end
    endtask

    task automatic checkInst(int i);
        logic [31:0] eh = 32'(pos[i] % hTot(i));
        logic [31:0] ev = 32'(pos[i] / hTot(i));
        logic [4:0] ef = expFlags(i);
        compared++;
        assert (obsH[i] === eh && obsV[i] === ev && obsF[i] === ef) else begin
            mismatched++;
            $error("FAIL u%0d state: observed h=%0d v=%0d hs/vs/de/ls/fs=%b, expected h=%0d v=%0d hs/vs/de/ls/fs=%b",
                   i, obsH[i], obsV[i], obsF[i], eh, ev, ef);
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 4; i++) checkInst(i);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        modelStep();
        checkAll();
    endtask

    int lsCnt, hsCnt, deCnt, fsCnt2, fsCnt1, vsCnt1;

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        modelReset();
        #12 checkAll();
        #4 reset_n = 1'b1;
        #1 checkAll();
        enable = 1'b1;
        lsCnt = 0; hsCnt = 0; deCnt = 0; fsCnt2 = 0; fsCnt1 = 0; vsCnt1 = 0;
        for (int n = 1; n <= 6600; n++) begin
            tick();
            if (n == 1) chk("first enabled clock hCount", obsH[0], 32'd1);
            if (n <= 2200) begin
                if (ls0) lsCnt++;
                if (hs0) hsCnt++;
                if (de0) deCnt++;
            end
            if (n <= 6552 && fs2) fsCnt2++;
            if (n <= 6300) begin
                if (fs1) fsCnt1++;
                if (vs1) vsCnt1++;
            end
        end
        chk("lineStart per 2200 clocks", 32'(lsCnt), 32'd1);
        chk("hSync clocks per line", 32'(hsCnt), 32'd44);
        chk("dataEnable clocks per line", 32'(deCnt), 32'd1920);
        chk("u2 frameStart per 91 frames", 32'(fsCnt2), 32'd91);
        chk("u1 frameStart per 15 frames", 32'(fsCnt1), 32'd15);
        chk("u1 vSync clocks per 15 frames", 32'(vsCnt1), 32'd1260);

        for (int n = 0; n < 2000; n++) begin
            enable = $urandom_range(0, 3) != 0;
            tick();
        end

        // Freeze at the last pixel of a frame, then resume into a frame start.
        enable = 1'b1;
        for (int n = 0; n < 100 && pos[2] != 71; n++) tick();
        chk("u2 at last hCount", obsH[2], 32'd11);
        chk("u2 at last vCount", obsV[2], 32'd5);
        enable = 1'b0;
        repeat (17) tick();
        chk("u2 hCount held", obsH[2], 32'd11);
        enable = 1'b1;
        tick();
        chk("u2 resume hCount", obsH[2], 32'd0);
        chk("u2 resume vCount", obsV[2], 32'd0);
        chk("u2 resume frameStart", 32'(fs2), 32'd1);
        for (int n = 0; n < 500 && pos[1] != 419; n++) tick();
        chk("u1 at last pixel", {obsV[1][15:0], obsH[1][15:0]}, {16'd14, 16'd27});
        enable = 1'b0;
        repeat (17) tick();
        enable = 1'b1;
        tick();
        chk("u1 resume frameStart", 32'(fs1), 32'd1);

        // Asynchronous reset mid-line, asserted and released between clock edges.
        for (int n = 0; n < 2300 && pos[0] % 2200 != 500; n++) tick();
        chk("u0 at hCount 500", obsH[0], 32'd500);
        #3 reset_n = 1'b0;
        modelReset();
        #1 checkAll();
        chk("u0 async reset hCount", obsH[0], 32'd0);
        #2 reset_n = 1'b1;
        #1 checkAll();

        for (int n = 0; n < 1000; n++) begin
            enable = $urandom_range(0, 4) != 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
